vdu_timing_gen: RTL and testbench

Parametrised raster timing generator for the VDU display path. Produces horizontal and vertical sync, display-enable, pixel coordinates and frame/line strobes for any VESA-style mode. Sync and display-enable are delayed through a configurable pipeline so they stay aligned with the character/pixel fetch latency of the downstream renderer. It replaces the fixed 640x480 counters inside the VDU, and sits between the pixel-clock domain reset logic and the text/graphics renderer.

---
 rtl/vdu_pkg.sv | 56 +++++
 rtl/vdu_delay_line.sv | 50 +++++
 rtl/vdu_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vdu_timing_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vdu_pkg.sv
// ---------------------------------------------------------------------------
// vdu_pkg
// Shared definitions for the VDU raster timing path.
//   - Default timing constants for 640x480 (25 MHz) and 800x600 (40 MHz).
//   - Sync polarity enum and a helper that maps an "active" decode onto the
//     physical pin level for a given polarity.
//   - Packed bundle of the delayed control signals (de/hsync/vsync).
// ---------------------------------------------------------------------------
package vdu_pkg;

  // Physical level of a sync pulse while it is asserted.
  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // Control bundle carried through the alignment delay line.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } vid_ctl_t;

  localparam int VID_CTL_W = $bits(vid_ctl_t);

  // 640x480 @ 60 Hz, 25.175/25 MHz pixel clock, both syncs negative.
  localparam int        VGA640_H_ACTIVE = 640;
  localparam int        VGA640_H_FP     = 16;
  localparam int        VGA640_H_SYNC   = 96;
  localparam int        VGA640_H_BP     = 48;
  localparam int        VGA640_V_ACTIVE = 480;
  localparam int        VGA640_V_FP     = 10;
  localparam int        VGA640_V_SYNC   = 2;
  localparam int        VGA640_V_BP     = 33;
  localparam sync_pol_e VGA640_H_POL    = SYNC_ACTIVE_LOW;
  localparam sync_pol_e VGA640_V_POL    = SYNC_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs positive.
  localparam int        SVGA800_H_ACTIVE = 800;
  localparam int        SVGA800_H_FP     = 40;
  localparam int        SVGA800_H_SYNC   = 128;
  localparam int        SVGA800_H_BP     = 88;
  localparam int        SVGA800_V_ACTIVE = 600;
  localparam int        SVGA800_V_FP     = 1;
  localparam int        SVGA800_V_SYNC   = 4;
  localparam int        SVGA800_V_BP     = 23;
  localparam sync_pol_e SVGA800_H_POL    = SYNC_ACTIVE_HIGH;
  localparam sync_pol_e SVGA800_V_POL    = SYNC_ACTIVE_HIGH;

  // Pin level for a sync signal: the polarity level while active, the
  // opposite level otherwise.
  function automatic logic sync_level(input logic active, input sync_pol_e pol);
    return active ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/vdu_delay_line.sv
// ---------------------------------------------------------------------------
// vdu_delay_line
// Clock-enabled shift register used to line sync/display-enable up with the
// downstream fetch latency. DEPTH = 0 degenerates to a plain wire.
//
// Ports:
//   clk_i   in   1      clock
//   rst_ni  in   1      asynchronous active-low reset, loads RST_VAL
//   en_i    in   1      clock enable; all stages hold while low
//   d_i     in   WIDTH  input word
//   q_o     out  WIDTH  d_i delayed by DEPTH enabled cycles
// ---------------------------------------------------------------------------
module vdu_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH < 0 || DEPTH > 7) begin : g_bad_depth
    $error("vdu_delay_line: DEPTH must be in 0..7");
  end

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vdu_timing_gen.sv
// ---------------------------------------------------------------------------
// vdu_timing_gen
// Parametrised raster timing generator. Free-running h/v counters are decoded
// into active-area and sync flags, captured into a stage-0 register set
// (x/y, fetch enable, line/frame strobes), and de/hsync/vsync are then
// delayed PIPE enabled cycles so they match the renderer's fetch latency.
//
// Ports:
//   vdu_clk        in   1   pixel clock
//   vdu_rst_n      in   1   asynchronous active-low reset
//   en             in   1   clock enable (DCM lock); everything holds when low
//   x_o            out  XW  horizontal position, stage 0
//   y_o            out  YW  vertical position, stage 0
//   fetch_de_o     out  1   active-area flag, stage 0
//   line_start_o   out  1   x_o==0 strobe, stage 0
//   frame_start_o  out  1   x_o==0 && y_o==0 strobe, stage 0
//   de_o           out  1   fetch_de_o delayed PIPE cycles
//   hsync_o        out  1   hsync (polarity H_POL) delayed PIPE cycles
//   vsync_o        out  1   vsync (polarity V_POL) delayed PIPE cycles
// ---------------------------------------------------------------------------
module vdu_timing_gen
  import vdu_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE     = 2,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          vdu_clk,
  input  logic          vdu_rst_n,
  input  logic          en,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          fetch_de_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (2 ** XW)) begin : g_bad_xw
    $error("vdu_timing_gen: H_TOTAL does not fit in XW bits");
  end
  if (V_TOTAL > (2 ** YW)) begin : g_bad_yw
    $error("vdu_timing_gen: V_TOTAL does not fit in YW bits");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("vdu_timing_gen: PIPE must be in 0..7");
  end

  localparam sync_pol_e H_POL_E = sync_pol_e'(H_POL);
  localparam sync_pol_e V_POL_E = sync_pol_e'(V_POL);

  // Inclusive upper bounds are used throughout so that a region ending
  // exactly at 2^XW (or 2^YW) never wraps its bound to zero.
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] H_SYN_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYN_LAST = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] V_SYN_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYN_LAST = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hsync: ~H_POL, vsync: ~V_POL};

  // Raster counters
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;

  // Stage-0 registers
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          fetch_de_q, line_start_q, frame_start_q;
  logic          hsync_q, vsync_q;

  // Decodes of the current counter values
  logic          h_act, v_act, h_syn, v_syn;
  logic          hsync_d, vsync_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    h_act = (H_ACTIVE != 0) && (h_q <= H_ACT_LAST);
    v_act = (V_ACTIVE != 0) && (v_q <= V_ACT_LAST);
    // vsync depends only on v_cnt, so it spans whole lines starting at h==0.
    h_syn = (H_SYNC != 0) && (h_q >= H_SYN_BEG) && (h_q <= H_SYN_LAST);
    v_syn = (V_SYNC != 0) && (v_q >= V_SYN_BEG) && (v_q <= V_SYN_LAST);

    hsync_d = sync_level(h_syn, H_POL_E);
    vsync_d = sync_level(v_syn, V_POL_E);
  end

  always_ff @(posedge vdu_clk or negedge vdu_rst_n) begin
    if (!vdu_rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fetch_de_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
    end else if (en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= h_q;
      y_q           <= v_q;
      fetch_de_q    <= h_act && v_act;
      line_start_q  <= (h_q == '0);
      frame_start_q <= (h_q == '0) && (v_q == '0);
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign fetch_de_o    = fetch_de_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

  // The delay line takes the stage-0 registers, so PIPE=0 leaves de_o
  // identical to fetch_de_o.
  vid_ctl_t ctl_s0, ctl_dly;

  assign ctl_s0 = '{de: fetch_de_q, hsync: hsync_q, vsync: vsync_q};

  vdu_delay_line #(
    .DEPTH   (PIPE),
    .WIDTH   (VID_CTL_W),
    .RST_VAL (CTL_IDLE)
  ) u_delay (
    .clk_i  (vdu_clk),
    .rst_ni (vdu_rst_n),
    .en_i   (en),
    .d_i    (ctl_s0),
    .q_o    (ctl_dly)
  );

  assign de_o    = ctl_dly.de;
  assign hsync_o = ctl_dly.hsync;
  assign vsync_o = ctl_dly.vsync;

endmodule

// File: tb/tb_vdu_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vdu_timing_gen
// Two instances on a 16x8 raster: A (H_POL=0, PIPE=2) and B (H_POL=1,
// PIPE=0). Expected outputs come from the number of enabled edges since
// reset, turned into raster positions with div/mod arithmetic.
// ---------------------------------------------------------------------------
module tb_vdu_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 8

  logic vdu_clk, vdu_rst_n, en;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_fde, a_ls, a_fs, a_de, a_hs, a_vs;
  logic b_fde, b_ls, b_fs, b_de, b_hs, b_vs;

  vdu_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE(2), .XW(10), .YW(10)
  ) dut_a (
    .vdu_clk(vdu_clk), .vdu_rst_n(vdu_rst_n), .en(en),
    .x_o(a_x), .y_o(a_y), .fetch_de_o(a_fde), .line_start_o(a_ls),
    .frame_start_o(a_fs), .de_o(a_de), .hsync_o(a_hs), .vsync_o(a_vs)
  );

  vdu_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b0), .PIPE(0), .XW(10), .YW(10)
  ) dut_b (
    .vdu_clk(vdu_clk), .vdu_rst_n(vdu_rst_n), .en(en),
    .x_o(b_x), .y_o(b_y), .fetch_de_o(b_fde), .line_start_o(b_ls),
    .frame_start_o(b_fs), .de_o(b_de), .hsync_o(b_hs), .vsync_o(b_vs)
  );

  initial vdu_clk = 1'b0;
  always #5 vdu_clk = ~vdu_clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_edges = 0;  // enabled edges since the last reset

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic fde, ls, fs, de, hs, vs;
  } exp_t;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, edges=%0d)", tag, obs, exp, $time, n_edges);
    end
  endtask

  // Stage 0 after n enabled edges shows raster position n-1; the delayed
  // outputs show position n-1-pipe, or the idle levels before that exists.
  function automatic exp_t model(input int n, input int pipe, input bit hpol, input bit vpol);
    exp_t e;
    int p, h, v;
    e = '0;
    if (n >= 1) begin
      p = n - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.fde = (h < HA) && (v < VA);
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
    end
    if (n - pipe >= 1) begin
      p = n - pipe - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e.de = (h < HA) && (v < VA);
      e.hs = (h >= HA + HF && h < HA + HF + HS) ? hpol : ~hpol;
      e.vs = (v >= VA + VF && v < VA + VF + VS) ? vpol : ~vpol;
    end else begin
      e.de = 1'b0;
      e.hs = ~hpol;
      e.vs = ~vpol;
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t ea, eb;
    ea = model(n_edges, 2, 1'b0, 1'b0);
    eb = model(n_edges, 0, 1'b1, 1'b0);
    chk_eq("a.x",  32'(a_x),   32'(ea.x));
    chk_eq("a.y",  32'(a_y),   32'(ea.y));
    chk_eq("a.fde", 32'(a_fde), 32'(ea.fde));
    chk_eq("a.ls", 32'(a_ls),  32'(ea.ls));
    chk_eq("a.fs", 32'(a_fs),  32'(ea.fs));
    chk_eq("a.de", 32'(a_de),  32'(ea.de));
    chk_eq("a.hs", 32'(a_hs),  32'(ea.hs));
    chk_eq("a.vs", 32'(a_vs),  32'(ea.vs));
    chk_eq("b.x",  32'(b_x),   32'(eb.x));
    chk_eq("b.y",  32'(b_y),   32'(eb.y));
    chk_eq("b.fde", 32'(b_fde), 32'(eb.fde));
    chk_eq("b.ls", 32'(b_ls),  32'(eb.ls));
    chk_eq("b.fs", 32'(b_fs),  32'(eb.fs));
    chk_eq("b.de", 32'(b_de),  32'(eb.de));
    chk_eq("b.hs", 32'(b_hs),  32'(eb.hs));
    chk_eq("b.vs", 32'(b_vs),  32'(eb.vs));
  endtask

  // Called just after a negedge: drive en, take one posedge, check on the
  // following negedge.
  task automatic step(input bit en_v);
    en = en_v;
    @(posedge vdu_clk);
    if (en_v && vdu_rst_n) n_edges++;
    @(negedge vdu_clk);
    check_all();
  endtask

  // Reset pulse entirely between two clock edges.
  task automatic async_reset_pulse();
    vdu_rst_n = 1'b0;
    #1;
    n_edges = 0;
    check_all();
    #1;
    vdu_rst_n = 1'b1;
  endtask

  initial begin
    int ls_cnt, fs_cnt;
    vdu_rst_n = 1'b0;
    en        = 1'b1;

    // Reset held across edges with en high: nothing may move.
    repeat (3) step(1'b1);

    vdu_rst_n = 1'b1;
    ls_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if (n_edges >= 1 && n_edges <= 128) begin
        ls_cnt += int'(a_ls);
        fs_cnt += int'(a_fs);
      end
    end
    chk_eq("ls_per_frame", 32'(ls_cnt), 32'd8);
    chk_eq("fs_per_frame", 32'(fs_cnt), 32'd1);

    // Random enable with 5-cycle en-low holds mid-line.
    for (int r = 0; r < 6; r++) begin
      int run;
      run = int'($urandom_range(20, 60));
      for (int i = 0; i < run; i++) step($urandom_range(0, 3) != 0);
      repeat (5) step(1'b0);
    end

    // Mid-frame asynchronous resets, with en both high and low.
    for (int r = 0; r < 4; r++) begin
      int run;
      run = int'($urandom_range(30, 150));
      for (int i = 0; i < run; i++) step($urandom_range(0, 4) != 0);
      en = r[0];
      async_reset_pulse();
      for (int i = 0; i < 40; i++) step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
